// File: rtl/csr_bus_pkg.sv
// rtl/csr_bus_pkg.sv - shared CSR bus types, op codes, state encodings and address helpers
//
// Holds everything the CSR initiator and its helpers agree on: the bus widths,
// the CSRRW/CSRRS/CSRRC op encoding, the controller state encoding and the
// read-only address-space check (CSR address bits [11:10] == 2'b11).
package csr_bus_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 32;

    typedef logic [CSR_ADDR_W-1:0] csr_addr_t;
    typedef logic [CSR_DATA_W-1:0] csr_data_t;

    typedef enum logic [1:0] {
        CSR_OP_RESERVED = 2'b00,
        CSR_OP_RW       = 2'b01,
        CSR_OP_RS       = 2'b10,
        CSR_OP_RC       = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_READ    = 2'b01,
        ST_WRITE   = 2'b10,
        ST_RESPOND = 2'b11
    } csr_state_e;

    // Top two address bits select the read-only CSR space.
    localparam logic [1:0] CSR_RO_SPACE = 2'b11;

    function automatic logic csr_is_read_only(input csr_addr_t addr);
        return addr[CSR_ADDR_W-1 -: 2] == CSR_RO_SPACE;
    endfunction

endpackage

// File: rtl/csr_access_controller_if.sv
// rtl/csr_access_controller_if.sv - request, response and CSR bus signals of the CSR initiator
//
// master : the controller side (takes requests, drives the CSR bus, returns responses)
// slave  : the environment side (execute stage, pipeline and CSR responders)
//   request  : reqValid/reqReady, reqOp, reqAddress, reqWriteData, reqWriteSuppress
//   response : rspValid/rspReady, rspData, rspIllegal
//   CSR bus  : csrReadEnable/Address, csrReadData, csrRequestOutput,
//              csrWriteEnable/Address/Data
interface csr_access_controller_if;
    import csr_bus_pkg::*;

    logic      reqValid;
    logic      reqReady;
    logic [1:0] reqOp;
    csr_addr_t reqAddress;
    csr_data_t reqWriteData;
    logic      reqWriteSuppress;

    logic      rspValid;
    logic      rspReady;
    csr_data_t rspData;
    logic      rspIllegal;

    logic      csrReadEnable;
    csr_addr_t csrReadAddress;
    csr_data_t csrReadData;
    logic      csrRequestOutput;
    logic      csrWriteEnable;
    csr_addr_t csrWriteAddress;
    csr_data_t csrWriteData;

    modport master (
        input  reqValid, reqOp, reqAddress, reqWriteData, reqWriteSuppress,
        output reqReady,
        output rspValid, rspData, rspIllegal,
        input  rspReady,
        output csrReadEnable, csrReadAddress,
        input  csrReadData, csrRequestOutput,
        output csrWriteEnable, csrWriteAddress, csrWriteData
    );

    modport slave (
        output reqValid, reqOp, reqAddress, reqWriteData, reqWriteSuppress,
        input  reqReady,
        input  rspValid, rspData, rspIllegal,
        output rspReady,
        input  csrReadEnable, csrReadAddress,
        output csrReadData, csrRequestOutput,
        input  csrWriteEnable, csrWriteAddress, csrWriteData
    );

endinterface

// File: rtl/csr_write_data_alu.sv
// rtl/csr_write_data_alu.sv - combinational read-modify-write merge for CSRRW/CSRRS/CSRRC
//
// op         in  CSR op code
// old_value  in  value read from the CSR bus
// write_data in  rs1 value or zero-extended zimm
// merged     out value to place on the write bus (0 for the reserved op)
module csr_write_data_alu
    import csr_bus_pkg::*;
(
    input  csr_op_e   op,
    input  csr_data_t old_value,
    input  csr_data_t write_data,
    output csr_data_t merged
);

    always_comb begin
        merged = '0;
        case (op)
            CSR_OP_RW: merged = write_data;
            CSR_OP_RS: merged = old_value | write_data;
            CSR_OP_RC: merged = old_value & ~write_data;
            default:   merged = '0;
        endcase
    end

endmodule

// File: rtl/csr_access_controller.sv
// rtl/csr_access_controller.sv - CSR bus initiator: read, legality check, RMW write, response
//
// clk  in  core clock
// rst  in  asynchronous active-low reset
// bus  csr_access_controller_if.master : request, response and CSR bus signals
//
// One access at a time: IDLE accepts, READ strobes the bus and samples the
// OR-combined data/hit, WRITE (only for a legal access that needs one) issues
// a single-cycle write strobe, RESPOND holds the result until consumed.
module csr_access_controller
    import csr_bus_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    csr_access_controller_if.master       bus
);

    csr_state_e state_q, state_d;
    csr_op_e    op_q, op_d;
    csr_addr_t  addr_q, addr_d;
    csr_data_t  wdata_q, wdata_d;
    logic       suppress_q, suppress_d;
    csr_data_t  old_q, old_d;
    logic       illegal_q, illegal_d;

    csr_data_t  merged;
    logic       write_needed;
    logic       access_illegal;
    logic       req_ready;
    logic       rsp_valid;
    logic       rd_en;
    csr_addr_t  rd_addr;
    logic       wr_en;
    csr_addr_t  wr_addr;
    csr_data_t  wr_data;

    csr_write_data_alu u_alu (
        .op         (op_q),
        .old_value  (old_q),
        .write_data (wdata_q),
        .merged     (merged)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        suppress_d = suppress_q;
        old_d      = old_q;
        illegal_d  = illegal_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        // RS/RC with an x0/zero source only read; RW always writes.
        write_needed = (op_q == CSR_OP_RW) ||
                       (((op_q == CSR_OP_RS) || (op_q == CSR_OP_RC)) && !suppress_q);
        access_illegal = (op_q == CSR_OP_RESERVED) || !bus.csrRequestOutput ||
                         (write_needed && csr_is_read_only(addr_q));

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.reqValid) begin
                    op_d       = csr_op_e'(bus.reqOp);
                    addr_d     = bus.reqAddress;
                    wdata_d    = bus.reqWriteData;
                    suppress_d = bus.reqWriteSuppress;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                rd_en     = 1'b1;
                rd_addr   = addr_q;
                illegal_d = access_illegal;
                old_d     = access_illegal ? '0 : bus.csrReadData;
                if (access_illegal || !write_needed) begin
                    state_d = ST_RESPOND;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = addr_q;
                wr_data = merged;
                state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                rsp_valid = 1'b1;
                if (bus.rspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= CSR_OP_RESERVED;
            addr_q     <= '0;
            wdata_q    <= '0;
            suppress_q <= 1'b0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            suppress_q <= suppress_d;
            old_q      <= old_d;
            illegal_q  <= illegal_d;
        end
    end

    // Reset already parks the FSM in IDLE; masking with rst keeps reqReady low
    // while reset is still asserted.
    assign bus.reqReady        = req_ready & rst;
    assign bus.rspValid        = rsp_valid;
    assign bus.rspData         = rsp_valid ? old_q : '0;
    assign bus.rspIllegal      = rsp_valid & illegal_q;
    assign bus.csrReadEnable   = rd_en;
    assign bus.csrReadAddress  = rd_addr;
    assign bus.csrWriteEnable  = wr_en;
    assign bus.csrWriteAddress = wr_addr;
    assign bus.csrWriteData    = wr_data;

endmodule

// File: tb/tb_csr_access_controller.sv
// tb/tb_csr_access_controller.sv - directed vector bench for csr_access_controller
module tb_csr_access_controller;

    logic clk;
    logic rst;

    csr_access_controller_if ifc ();

    csr_access_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        sup;
        logic        hit;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rsp;
        logic        exp_ill;
        int          exp_rsp_cyc;
    } vec_t;

    vec_t vecs [10];

    int n_checks = 0;
    int n_fail   = 0;

    // Responder model: answers only when strobed at the address it owns.
    logic [11:0] cur_addr;
    logic        cur_hit;
    logic [31:0] cur_rdata;

    always_comb begin
        ifc.csrReadData      = '0;
        ifc.csrRequestOutput = 1'b0;
        if (ifc.csrReadEnable && ifc.csrReadAddress == cur_addr && cur_hit) begin
            ifc.csrReadData      = cur_rdata;
            ifc.csrRequestOutput = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        cur_addr             = v.addr;
        cur_hit              = v.hit;
        cur_rdata            = v.rdata;
        ifc.reqValid         = 1'b1;
        ifc.reqOp            = v.op;
        ifc.reqAddress       = v.addr;
        ifc.reqWriteData     = v.wdata;
        ifc.reqWriteSuppress = v.sup;
    endtask

    // Issues one access from IDLE and returns at the negedge of the first
    // rspValid cycle (or after the cycle budget runs out).
    task automatic run_vec(input vec_t v, input int tag);
        int          we_cnt;
        int          we_cyc;
        int          rsp_cyc;
        int          stray;
        logic [31:0] wd;
        logic [31:0] wa;
        logic [31:0] rd;
        logic        ri;
        we_cnt = 0; we_cyc = -1; rsp_cyc = -1; stray = 0;
        wd = '0; wa = '0; rd = '0; ri = 1'b0;
        @(negedge clk);
        drive_req(v);
        @(posedge clk);
        for (int c = 1; c <= 8 && rsp_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check($sformatf("v%0d read_enable", tag), 32'(ifc.csrReadEnable), 32'd1);
                check($sformatf("v%0d read_address", tag), 32'(ifc.csrReadAddress), 32'(v.addr));
                check($sformatf("v%0d req_ready_busy", tag), 32'(ifc.reqReady), 32'd0);
                ifc.reqValid = 1'b0;
            end
            if (ifc.csrWriteEnable) begin
                we_cnt++;
                we_cyc = c;
                wd = ifc.csrWriteData;
                wa = 32'(ifc.csrWriteAddress);
            end else if (ifc.csrWriteData != 0 || ifc.csrWriteAddress != 0) begin
                stray++;
            end
            if (ifc.rspValid) begin
                rsp_cyc = c;
                rd = ifc.rspData;
                ri = ifc.rspIllegal;
            end
        end
        check($sformatf("v%0d write_count", tag), 32'(we_cnt), v.exp_we ? 32'd1 : 32'd0);
        check($sformatf("v%0d write_bus_idle", tag), 32'(stray), 32'd0);
        if (v.exp_we) begin
            check($sformatf("v%0d write_cycle", tag), 32'(we_cyc), 32'd2);
            check($sformatf("v%0d write_data", tag), wd, v.exp_wdata);
            check($sformatf("v%0d write_address", tag), wa, 32'(v.addr));
        end
        check($sformatf("v%0d rsp_cycle", tag), 32'(rsp_cyc), 32'(v.exp_rsp_cyc));
        check($sformatf("v%0d rsp_data", tag), rd, v.exp_rsp);
        check($sformatf("v%0d rsp_illegal", tag), 32'(ri), 32'(v.exp_ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op     addr     wdata         sup  hit  rdata         we    exp_wdata     exp_rsp       ill   cyc
        vecs[0] = '{2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0, 3};
        vecs[1] = '{2'b10, 12'h300, 32'h0000000F, 1'b0, 1'b1, 32'h000000F0, 1'b1, 32'h000000FF, 32'h000000F0, 1'b0, 3};
        vecs[2] = '{2'b11, 12'h300, 32'h00000030, 1'b0, 1'b1, 32'h000000F0, 1'b1, 32'h000000C0, 32'h000000F0, 1'b0, 3};
        vecs[3] = '{2'b10, 12'hC00, 32'h00000000, 1'b1, 1'b1, 32'h00012345, 1'b0, 32'h0,         32'h00012345, 1'b0, 2};
        vecs[4] = '{2'b10, 12'hC00, 32'h00000004, 1'b0, 1'b1, 32'h00012345, 1'b0, 32'h0,         32'h00000000, 1'b1, 2};
        vecs[5] = '{2'b01, 12'h7FF, 32'h00000055, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h0,         32'h00000000, 1'b1, 2};
        vecs[6] = '{2'b00, 12'h340, 32'h000000FF, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,         32'h00000000, 1'b1, 2};
        vecs[7] = '{2'b11, 12'hFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000001, 1'b0, 32'h0,         32'h80000001, 1'b0, 2};
        vecs[8] = '{2'b01, 12'hC01, 32'h00000000, 1'b1, 1'b1, 32'h00000077, 1'b0, 32'h0,         32'h00000000, 1'b1, 2};
        vecs[9] = '{2'b11, 12'hBFF, 32'hFFFF0000, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'h00005678, 32'h12345678, 1'b0, 3};

        rst                  = 1'b0;
        ifc.reqValid         = 1'b0;
        ifc.reqOp            = 2'b00;
        ifc.reqAddress       = '0;
        ifc.reqWriteData     = '0;
        ifc.reqWriteSuppress = 1'b0;
        ifc.rspReady         = 1'b1;
        cur_addr             = '0;
        cur_hit              = 1'b0;
        cur_rdata            = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(ifc.reqReady), 32'd0);
        check("reset rsp_valid", 32'(ifc.rspValid), 32'd0);
        check("reset read_enable", 32'(ifc.csrReadEnable), 32'd0);
        check("reset write_enable", 32'(ifc.csrWriteEnable), 32'd0);
        check("reset rsp_data", ifc.rspData, 32'd0);
        rst = 1'b1;
        #1;
        check("release req_ready", 32'(ifc.reqReady), 32'd1);

        // Table-driven accesses
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
            @(negedge clk);
            check($sformatf("v%0d back_to_idle", i), 32'(ifc.reqReady), 32'd1);
            check($sformatf("v%0d rsp_dropped", i), 32'(ifc.rspValid), 32'd0);
        end

        // Backpressure: response held, a new request is not taken
        ifc.rspReady = 1'b0;
        run_vec(vecs[0], 100);
        drive_req(vecs[1]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d rsp_valid", k), 32'(ifc.rspValid), 32'd1);
            check($sformatf("bp%0d rsp_data", k), ifc.rspData, 32'h12345678);
            check($sformatf("bp%0d rsp_illegal", k), 32'(ifc.rspIllegal), 32'd0);
            check($sformatf("bp%0d req_ready", k), 32'(ifc.reqReady), 32'd0);
            check($sformatf("bp%0d read_enable", k), 32'(ifc.csrReadEnable), 32'd0);
        end
        ifc.rspReady = 1'b1;
        ifc.reqValid = 1'b0;
        @(negedge clk);
        check("bp idle req_ready", 32'(ifc.reqReady), 32'd1);
        check("bp idle rsp_valid", 32'(ifc.rspValid), 32'd0);
        run_vec(vecs[1], 101);
        @(negedge clk);

        // Reset during WRITE
        drive_req(vecs[0]);
        @(posedge clk);
        @(negedge clk);
        ifc.reqValid = 1'b0;
        @(negedge clk);
        check("rstw write_enable_before", 32'(ifc.csrWriteEnable), 32'd1);
        rst = 1'b0;
        #1;
        check("rstw write_enable_dropped", 32'(ifc.csrWriteEnable), 32'd0);
        check("rstw write_data_dropped", ifc.csrWriteData, 32'd0);
        check("rstw req_ready_in_reset", 32'(ifc.reqReady), 32'd0);
        @(negedge clk);
        check("rstw no_rsp", 32'(ifc.rspValid), 32'd0);
        rst = 1'b1;
        #1;
        check("rstw req_ready_after", 32'(ifc.reqReady), 32'd1);
        @(negedge clk);
        check("rstw still_no_rsp", 32'(ifc.rspValid), 32'd0);
        run_vec(vecs[2], 102);
        @(negedge clk);
        check("final idle", 32'(ifc.reqReady), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_controller.md
# csr_access_controller

Initiator side of the core's CSR bus: accepts one CSR instruction at a time from the execute stage, issues the read strobe/address to all CSR register blocks, and collects the OR-combined read data and hit flag. It computes the read-modify-write value for CSRRW/CSRRS/CSRRC and issues a single-cycle write strobe. It returns the old value, or an illegal-access flag, to the pipeline. It sits between the execute stage and the shared CSR bus that timer, status and peripheral CSR blocks respond on.

## Interface
- No parameters; CSR address width fixed at 12, data width at 32.
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- reqValid  in  1  execute stage presents a CSR access
- reqReady  out  1  controller can accept; high only in IDLE
- reqOp  in  2  01=RW, 10=RS (set), 11=RC (clear), 00=reserved
- reqAddress  in  12  CSR address
- reqWriteData  in  32  rs1 value or zero-extended zimm
- reqWriteSuppress  in  1  rs1/zimm field is x0/0 for RS/RC: no write is performed
- rspValid  out  1  result available; held until rspReady
- rspReady  in  1  pipeline consumes result
- rspData  out  32  old CSR value; 0 when illegal
- rspIllegal  out  1  access faulted: no CSR hit, reserved op, or write to a read-only CSR
- csrReadEnable  out  1  bus read strobe
- csrReadAddress  out  12  bus read address
- csrReadData  in  32  OR of all responder read data; 0 when none hit
- csrRequestOutput  in  1  OR of all responder hit flags
- csrWriteEnable  out  1  bus write strobe, single cycle
- csrWriteAddress  out  12  bus write address
- csrWriteData  out  32  value to write

## Operation
- FSM states: IDLE, READ, WRITE, RESPOND. Encoding is two bits.
- **IDLE**
  - reqReady=1.
  - On reqValid, latch op, address, writeData and suppress, then go to READ.
- **READ**
  - csrReadEnable=1 and csrReadAddress=latched address.
  - Capture csrReadData into oldValue and csrRequestOutput into hit.
  - writeNeeded = (op==RW) or (op in RS/RC and !suppress).
  - Illegal if any of: op==00; !hit; writeNeeded with address[11:10]==2'b11 (read-only space).
  - If illegal, go to RESPOND with illegal=1 and oldValue forced to 0.
  - Else if writeNeeded, go to WRITE.
  - Else go to RESPOND.
- **WRITE**
  - csrWriteEnable=1 and csrWriteAddress=latched address.
  - csrWriteData: RW gives writeData; RS gives oldValue|writeData; RC gives oldValue&~writeData.
  - Then go to RESPOND.
- **RESPOND**
  - rspValid=1, with rspData and rspIllegal from registers.
  - On rspReady, go to IDLE.
- All bus strobes, addresses and write data are 0 outside their own state. No write is ever issued for an illegal access.
- RW with rd=x0 still performs the read. Read side effects are the responders' concern.

## Timing
- Reset (rst=0), applied asynchronously:
  - state goes to IDLE and every registered field clears.
  - Outputs: reqReady=1 once rst is released (0 while in reset), all others 0.
- Reset mid-operation aborts the access at once.
  - A pending WRITE strobe drops in the same instant, because strobes decode from state.
  - No response is produced.
- Accept edge = cycle 0. READ occupies cycle 1; WRITE (if any) occupies cycle 2.
- rspValid first asserts in cycle 2 (no write) or cycle 3 (write).
- Minimum spacing between accepted requests: 3 cycles (read-only) or 4 cycles (RMW), with rspReady held high.
- A new request is not accepted in the cycle rspReady is taken. IDLE is re-entered first.
- csrReadData and csrRequestOutput are sampled only at the READ-state edge and ignored otherwise.
- rspValid, rspData and rspIllegal stay stable while rspValid=1 and rspReady=0.

## Structure
- Shared package csr_bus_pkg holds:
  - op codes (CSR_OP_RW/RS/RC/RESERVED) and state encodings;
  - the read-only address-space mask 2'b11 at [11:10];
  - CSR address/data width constants.
- One natural sub-module, csr_write_data_alu: combinational RW/RS/RC merge of oldValue and writeData.
- Everything else lives in csr_access_controller: FSM, latches, legality check.

## Test plan
- Reset then RW: addr 0x340 (hit, old 0x12345678), data 0xDEADBEEF.
  - Expect csrWriteEnable one cycle in cycle 2 with data 0xDEADBEEF.
  - Expect rspData=0x12345678, rspIllegal=0, rspValid in cycle 3.
- RS and RC: old 0x0000_00F0, data 0x0000_000F.
  - RS writes 0x0000_00FF.
  - RC with data 0x30 writes 0x0000_00C0.
  - Both return 0x0000_00F0.
- Read of timer CSR 0xC00 via RS with suppress=1.
  - Expect no write strobe, rspValid in cycle 2, rspData=responder value.
  - Same with suppress=0: rspIllegal=1, rspData=0, no write strobe.
- Unmapped address 0x7FF (csrRequestOutput=0) and op=00.
  - Each returns rspIllegal=1, rspData=0, and never asserts csrWriteEnable.
- Backpressure: hold rspReady=0 for 5 cycles.
  - Response stays stable; reqReady stays 0; a new reqValid is ignored until IDLE.
- Drive rst low during WRITE.
  - csrWriteEnable drops immediately; no rspValid; after release, reqReady=1 and the next access completes normally.
